spi_sclk_engine: RTL and testbench

Parametrised SPI master clock/framing engine, successor to the fixed-divide SCLK generator. Driven by a start/done handshake instead of an external state-machine code. Generates chip select, SCLK in all four CPOL/CPHA modes, a runtime-programmable divider and frame length, CS setup/hold guard times, and single-cycle launch/sample strobes for the shift-register datapath. Sits between the ADC transaction controller and the SPI pads.

---
 rtl/spi_sclk_engine.sv | 192 +++++++++++++++++++
 tb/tb_spi_sclk_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sclk_engine.sv
// spi_sclk_engine: SPI master clock/framing engine.
// Produces chip select, SCLK in all four CPOL/CPHA modes, a per-frame divider and
// frame length, CS setup/hold guard times, and launch/sample strobes for the
// shift-register datapath. All outputs are registered.
// Optional macro SPI_SCLK_MIN_GAP_EN: enforce MIN_GAP idle cycles (CS_N high)
// between frames; start is ignored during that gap.
module spi_sclk_engine #(
   parameter int DIV_W    = 8,
   parameter int CNT_W    = 6,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int MIN_GAP  = 4
) (
   input  logic             system_clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [DIV_W-1:0] clk_div,
   input  logic [CNT_W-1:0] num_cycles,
   input  logic             cpol,
   input  logic             cpha,
   output logic             SPI_SCLK,
   output logic             SPI_CS_N,
   output logic             busy,
   output logic             done,
   output logic             launch_strobe,
   output logic             sample_strobe,
   output logic [CNT_W-1:0] CLOCK_CYCLES
);

   // One shared timer covers CS setup, CS hold and the inter-frame gap.
   localparam int TMR_MAX_SH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int TMR_MAX    = (TMR_MAX_SH > MIN_GAP) ? TMR_MAX_SH : MIN_GAP;
   localparam int TMR_W      = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
   localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);
`ifdef SPI_SCLK_MIN_GAP_EN
   localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(MIN_GAP - 1);
`else
   localparam logic [TMR_W-1:0] GAP_LOAD   = '0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_HOLD} state_t;

   state_t             r_state, w_state_nx;
   logic               r_sclk, w_sclk_nx;
   logic               r_cs_n, w_cs_n_nx;
   logic               r_busy, w_busy_nx;
   logic               r_done, w_done_nx;
   logic               r_launch, w_launch_nx;
   logic               r_sample, w_sample_nx;
   logic [CNT_W-1:0]   r_cc, w_cc_nx;
   logic [DIV_W-1:0]   r_div, w_div_nx;
   logic [CNT_W:0]     r_edge, w_edge_nx, w_edge_inc;
   logic [TMR_W-1:0]   r_tmr, w_tmr_nx;
   logic               w_accept;
   logic               w_gap_open;

   // Frame configuration, captured only when a start is accepted.
   logic [DIV_W-1:0]   r_clk_div;
   logic [CNT_W-1:0]   r_num;
   logic               r_cpha;

   // Next-state and next-output logic for the framing FSM.
   always_comb begin
      w_state_nx  = r_state;
      w_sclk_nx   = r_sclk;
      w_cs_n_nx   = r_cs_n;
      w_busy_nx   = r_busy;
      w_done_nx   = 1'b0;
      w_launch_nx = 1'b0;
      w_sample_nx = 1'b0;
      w_cc_nx     = r_cc;
      w_div_nx    = r_div;
      w_edge_nx   = r_edge;
      w_tmr_nx    = r_tmr;
      w_accept    = 1'b0;
      w_edge_inc  = r_edge + (CNT_W+1)'(1);
      w_gap_open  = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_sclk_nx = cpol;
`ifdef SPI_SCLK_MIN_GAP_EN
            w_gap_open = (r_tmr == '0);
            if (!w_gap_open) w_tmr_nx = r_tmr - TMR_W'(1);
`endif
            if (start && w_gap_open) begin
               w_accept    = 1'b1;
               w_state_nx  = S_SETUP;
               w_cs_n_nx   = 1'b0;
               w_busy_nx   = 1'b1;
               w_cc_nx     = '0;
               w_div_nx    = '0;
               w_edge_nx   = '0;
               w_tmr_nx    = '0;
               // With cpha=0 the first bit must be on MOSI before the first edge.
               w_launch_nx = ~cpha;
            end
         end
         S_SETUP: begin
            if (r_tmr == SETUP_LAST) begin
               w_tmr_nx   = '0;
               w_div_nx   = '0;
               w_state_nx = (r_num == '0) ? S_HOLD : S_RUN;
            end else begin
               w_tmr_nx = r_tmr + TMR_W'(1);
            end
         end
         S_RUN: begin
            if (r_div == r_clk_div) begin
               w_div_nx  = '0;
               w_sclk_nx = ~r_sclk;
               w_edge_nx = w_edge_inc;
               if (w_edge_inc[0]) begin
                  // Leading edge.
                  w_sample_nx = ~r_cpha;
                  w_launch_nx = r_cpha;
               end else begin
                  // Trailing edge; no launch after the last bit in cpha=0.
                  w_sample_nx = r_cpha;
                  w_launch_nx = ~r_cpha && (w_edge_inc != {r_num, 1'b0});
                  w_cc_nx     = r_cc + CNT_W'(1);
               end
               if (w_edge_inc == {r_num, 1'b0}) begin
                  w_state_nx = S_HOLD;
                  w_tmr_nx   = '0;
               end
            end else begin
               w_div_nx = r_div + DIV_W'(1);
            end
         end
         S_HOLD: begin
            if (r_tmr == HOLD_LAST) begin
               w_state_nx = S_IDLE;
               w_cs_n_nx  = 1'b1;
               w_done_nx  = 1'b1;
               w_busy_nx  = 1'b0;
               w_tmr_nx   = GAP_LOAD;
            end else begin
               w_tmr_nx = r_tmr + TMR_W'(1);
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // State and registered outputs; reset forces an idle, deselected bus.
   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_sclk   <= 1'b0;
         r_cs_n   <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_launch <= 1'b0;
         r_sample <= 1'b0;
         r_cc     <= '0;
         r_div    <= '0;
         r_edge   <= '0;
         r_tmr    <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_sclk   <= w_sclk_nx;
         r_cs_n   <= w_cs_n_nx;
         r_busy   <= w_busy_nx;
         r_done   <= w_done_nx;
         r_launch <= w_launch_nx;
         r_sample <= w_sample_nx;
         r_cc     <= w_cc_nx;
         r_div    <= w_div_nx;
         r_edge   <= w_edge_nx;
         r_tmr    <= w_tmr_nx;
      end
   end

   // Capture frame configuration at accepted start; later input changes are ignored.
   always_ff @(posedge system_clock) begin
      if (w_accept) begin
         r_clk_div <= clk_div;
         r_num     <= num_cycles;
         r_cpha    <= cpha;
      end
   end

   assign SPI_SCLK      = r_sclk;
   assign SPI_CS_N      = r_cs_n;
   assign busy          = r_busy;
   assign done          = r_done;
   assign launch_strobe = r_launch;
   assign sample_strobe = r_sample;
   assign CLOCK_CYCLES  = r_cc;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Scoreboard bench for spi_sclk_engine: the stimulus pushes the hand-computed
// frame profile, a negedge monitor measures each frame and compares on done.
module tb_spi_sclk_engine;

   logic       system_clock = 1'b0;
   logic       reset_n;
   logic       start;
   logic [7:0] clk_div;
   logic [5:0] num_cycles;
   logic       cpol;
   logic       cpha;
   logic       SPI_SCLK;
   logic       SPI_CS_N;
   logic       busy;
   logic       done;
   logic       launch_strobe;
   logic       sample_strobe;
   logic [5:0] CLOCK_CYCLES;

`ifdef SPI_SCLK_MIN_GAP_EN
   localparam int EXP_GAP = 4;
`else
   localparam int EXP_GAP = 1;
`endif

   spi_sclk_engine #(.DIV_W(8), .CNT_W(6), .CS_SETUP(2), .CS_HOLD(2), .MIN_GAP(4)) dut (
      .system_clock (system_clock),
      .reset_n      (reset_n),
      .start        (start),
      .clk_div      (clk_div),
      .num_cycles   (num_cycles),
      .cpol         (cpol),
      .cpha         (cpha),
      .SPI_SCLK     (SPI_SCLK),
      .SPI_CS_N     (SPI_CS_N),
      .busy         (busy),
      .done         (done),
      .launch_strobe(launch_strobe),
      .sample_strobe(sample_strobe),
      .CLOCK_CYCLES (CLOCK_CYCLES)
   );

   always #5 system_clock = ~system_clock;

   typedef struct {
      int cs_low;
      int rises;
      int falls;
      int samp;
      int laun;
      int samp_rise;
      int laun_fall;
      int hmin;
      int hmax;
      int cc;
      int first_off;
      int sclk_end;
      int gap;       // -1: gap before this frame not checked
   } exp_t;

   exp_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int cs_low, input int rises, input int falls,
                               input int samp, input int laun, input int samp_rise,
                               input int laun_fall, input int hmin, input int hmax,
                               input int cc, input int first_off, input int sclk_end,
                               input int gap);
      exp_t e;
      e.cs_low = cs_low; e.rises = rises; e.falls = falls; e.samp = samp;
      e.laun = laun; e.samp_rise = samp_rise; e.laun_fall = laun_fall;
      e.hmin = hmin; e.hmax = hmax; e.cc = cc; e.first_off = first_off;
      e.sclk_end = sclk_end; e.gap = gap;
      return e;
   endfunction

   // Monitor: measure each CS-low window, compare against the queue on done.
   initial begin
      int   cyc = 0, fall_cyc = 0, last_edge = 0, hi_cnt = 0;
      int   m_cs = 0, m_r = 0, m_f = 0, m_s = 0, m_l = 0, m_sr = 0, m_lf = 0;
      int   m_hmin = 999, m_hmax = 0, m_first = -1, m_gap = 0, m_badbusy = 0;
      logic p_cs = 1'b1, p_sclk = 1'b0, edg;
      exp_t e;
      forever begin
         @(negedge system_clock);
         cyc++;
         if (p_cs && !SPI_CS_N) begin
            m_cs = 0; m_r = 0; m_f = 0; m_s = 0; m_l = 0; m_sr = 0; m_lf = 0;
            m_hmin = 999; m_hmax = 0; m_first = -1; m_badbusy = 0;
            m_gap = hi_cnt; hi_cnt = 0; fall_cyc = cyc;
         end
         if (SPI_CS_N) hi_cnt++;
         else begin
            m_cs++;
            if (!busy) m_badbusy++;
            edg = (SPI_SCLK != p_sclk);
            if (edg) begin
               if (m_r + m_f == 0) m_first = cyc - fall_cyc;
               else begin
                  if (cyc - last_edge < m_hmin) m_hmin = cyc - last_edge;
                  if (cyc - last_edge > m_hmax) m_hmax = cyc - last_edge;
               end
               last_edge = cyc;
               if (SPI_SCLK) m_r++; else m_f++;
            end
            if (sample_strobe) m_s++;
            if (launch_strobe) m_l++;
            if (sample_strobe && edg && SPI_SCLK) m_sr++;
            if (launch_strobe && edg && !SPI_SCLK) m_lf++;
         end
         if (done) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = q.pop_front();
               chk("cs_low_cycles", m_cs, e.cs_low);
               chk("sclk_rises", m_r, e.rises);
               chk("sclk_falls", m_f, e.falls);
               chk("sample_strobes", m_s, e.samp);
               chk("launch_strobes", m_l, e.laun);
               chk("sample_on_rise", m_sr, e.samp_rise);
               chk("launch_on_fall", m_lf, e.laun_fall);
               chk("half_period_min", m_hmin, e.hmin);
               chk("half_period_max", m_hmax, e.hmax);
               chk("clock_cycles_at_done", int'(CLOCK_CYCLES), e.cc);
               chk("first_edge_offset", m_first, e.first_off);
               chk("sclk_at_done", int'(SPI_SCLK), e.sclk_end);
               chk("cs_n_at_done", int'(SPI_CS_N), 1);
               chk("busy_at_done", int'(busy), 0);
               chk("busy_low_in_frame", m_badbusy, 0);
               if (e.gap >= 0) chk("cs_high_gap", m_gap, e.gap);
            end
         end
         p_cs = SPI_CS_N;
         p_sclk = SPI_SCLK;
      end
   end

   task automatic pulse_start();
      @(posedge system_clock); #1 start = 1'b1;
      @(posedge system_clock); #1 start = 1'b0;
   endtask

   task automatic set_cfg(input int div, input int num, input logic pol, input logic pha);
      @(posedge system_clock); #1;
      clk_div = 8'(div); num_cycles = 6'(num); cpol = pol; cpha = pha;
      repeat (3) @(posedge system_clock);
   endtask

   task automatic wait_empty(input string name, input int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         @(posedge system_clock);
         n++;
      end
      if (q.size() != 0) begin
         chk({name, "_timeout"}, q.size(), 0);
         q.delete();
      end
      repeat (3) @(posedge system_clock);
   endtask

   initial begin
      int   e_cnt, bud, falls;
      logic ps, pc;
      reset_n = 1'b0; start = 1'b0; clk_div = 8'd6; num_cycles = 6'd24;
      cpol = 1'b0; cpha = 1'b0;
      repeat (3) @(negedge system_clock);
      chk("rst_cs_n", int'(SPI_CS_N), 1);
      chk("rst_sclk", int'(SPI_SCLK), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_launch", int'(launch_strobe), 0);
      chk("rst_sample", int'(sample_strobe), 0);
      chk("rst_clock_cycles", int'(CLOCK_CYCLES), 0);
      reset_n = 1'b1;
      repeat (3) @(posedge system_clock);

      // Mode 0, div 6, 24 cycles; a mid-frame start and config change must be ignored.
      set_cfg(6, 24, 1'b0, 1'b0);
      q.push_back(mk(340, 24, 24, 24, 24, 24, 23, 7, 7, 24, 9, 0, -1));
      pulse_start();
      repeat (50) @(posedge system_clock);
      #1 clk_div = 8'd2; num_cycles = 6'd3; cpha = 1'b1;
      pulse_start();
      wait_empty("mode0", 1000);

      // Mode 3: idle high, launch on falling, sample on rising.
      set_cfg(6, 24, 1'b1, 1'b1);
      q.push_back(mk(340, 24, 24, 24, 24, 24, 24, 7, 7, 24, 9, 1, -1));
      pulse_start();
      wait_empty("mode3", 1000);

      // Fastest divider, single cycle.
      set_cfg(0, 1, 1'b0, 1'b0);
      q.push_back(mk(6, 1, 1, 1, 1, 1, 0, 1, 1, 1, 3, 0, -1));
      pulse_start();
      wait_empty("div0", 100);

      // Empty frame: no edges, only the pre-launch.
      set_cfg(3, 0, 1'b0, 1'b0);
      q.push_back(mk(4, 0, 0, 0, 1, 0, 0, 999, 0, 0, -1, 0, -1));
      pulse_start();
      wait_empty("num0", 100);

      // Reset at the 10th edge of a frame: no done, bus released immediately.
      set_cfg(2, 5, 1'b0, 1'b1);
      pulse_start();
      e_cnt = 0; bud = 0; ps = SPI_SCLK;
      while (e_cnt < 10 && bud < 500) begin
         @(negedge system_clock);
         if (!SPI_CS_N && SPI_SCLK != ps) e_cnt++;
         ps = SPI_SCLK;
         bud++;
      end
      chk("reach_edge10", e_cnt, 10);
      reset_n = 1'b0;
      #1;
      chk("abort_cs_n", int'(SPI_CS_N), 1);
      chk("abort_sclk", int'(SPI_SCLK), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_clock_cycles", int'(CLOCK_CYCLES), 0);
      repeat (3) @(negedge system_clock);
      reset_n = 1'b1;
      repeat (4) @(posedge system_clock);
      q.push_back(mk(34, 5, 5, 5, 5, 0, 0, 3, 3, 5, 5, 0, -1));
      pulse_start();
      wait_empty("after_reset", 200);

      // Start held high: back-to-back frames separated by the minimum gap.
      set_cfg(1, 3, 1'b0, 1'b0);
      q.push_back(mk(16, 3, 3, 3, 3, 3, 2, 2, 2, 3, 4, 0, -1));
      q.push_back(mk(16, 3, 3, 3, 3, 3, 2, 2, 2, 3, 4, 0, EXP_GAP));
      @(posedge system_clock); #1 start = 1'b1;
      falls = 0; bud = 0; pc = SPI_CS_N;
      while (falls < 2 && bud < 500) begin
         @(negedge system_clock);
         if (pc && !SPI_CS_N) falls++;
         pc = SPI_CS_N;
         bud++;
      end
      chk("held_second_frame", falls, 2);
      @(posedge system_clock); #1 start = 1'b0;
      wait_empty("held", 200);

      repeat (50) @(posedge system_clock);
      chk("scoreboard_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
